// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown timer with a one-cycle done pulse on arrival at zero.
// WRAP selects between stopping at zero and reloading all-nines on the next enabled tick.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  input  logic                in_i,
  output logic [4*DIGITS-1:0] cnt_o,
  output logic                busy_o,
  output logic                zero_o,
  output logic                done_o
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [W-1:0]   loadSan;
  logic [W-1:0]   cntDec;
  logic [W-1:0]   cntNines;

  // Clamp any non-BCD preset digit to 9 so the count register only ever holds BCD.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcdDecrement(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] allNines();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign loadSan  = sanitize(load_val_i);
  assign cntDec   = bcdDecrement(cnt_q);
  assign cntNines = allNines();

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load_i) begin
      cnt_d   = loadSan;
      state_d = (loadSan != '0) ? RUN : IDLE;
    end else if (state_q == RUN && in_i) begin
      if (cnt_q != '0) begin
        cnt_d = cntDec;
        if (cnt_q == CNT_ONE) begin
          done_d  = 1'b1;
          state_d = WRAP ? RUN : IDLE;
        end
      end else if (WRAP) begin
        cnt_d = cntNines;
      end else begin
        // RUN at zero cannot arise without WRAP; fall back to IDLE if it ever does.
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == RUN);
  assign zero_o = (cnt_q == '0);
  assign done_o = done_q;

endmodule
